chunked_adder: RTL and testbench
================================

# chunked_adder

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, least-significant chunk first, with carry rippled between cycles through a carry register. It generalises the team's combinational four-bit full adder in three ways: operand width, per-cycle slice width, and an add/subtract mode. It sits between an operand source and a result consumer, using a start/done handshake, and trades latency for a short carry chain.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- N (localparam), WIDTH/CHUNK, number of RUN cycles.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- c_in  input  1  carry-in (add) or borrow-in (sub); captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when results update.
- s  output  WIDTH  sum/difference; registered.
- c_out  output  1  carry out of bit WIDTH-1 of the internal addition.
- ovf  output  1  signed (two's-complement) overflow.

## Operation
- Internal addition:
  - Add: a + b + c_in.
  - Sub: a + ~b + ~c_in, giving a − b − c_in.
  - In sub mode, c_out = 1 means no borrow.
- FSM states are IDLE, RUN and DONE.
  - IDLE: if start, capture a, the effective B (b or ~b), and the effective carry (c_in or ~c_in). Clear the chunk index and go to RUN.
  - RUN: each cycle, add chunk[idx] of A and B plus the carry register. Write the CHUNK-bit sum into the working register and the chunk carry-out into the carry register, then increment idx.
  - RUN exit: after the chunk with idx = N−1, go to DONE.
  - On the RUN→DONE edge: load s from the working register and c_out from the final carry. Set ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), then raise done.
  - DONE: lasts one cycle. If start is high, capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- s, c_out and ovf change only on the edge that raises done. They hold their values through IDLE and through a later RUN until the next done.
- start in RUN is ignored: no capture and no restart.
- a, b, sub and c_in are don't-care except on a capturing edge.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, s=0, c_out=0, ovf=0.
  - Working register, carry register and idx are cleared.
- Reset mid-RUN aborts the operation. No done is produced. Outputs return to 0.
- Start is captured at edge E0.
  - busy=1 after E0 through edge E_N.
  - Results become valid and done=1 after E_N, i.e. N+... latency of N edges from capture to result.
  - done falls after E_{N+1}.
- Back-to-back: start high during the done cycle is captured at E_{N+1}, so busy=1 after that edge. The throughput is one operation per N+1 cycles.
- N=1 (CHUNK=WIDTH) is legal and behaves as a single RUN cycle.
- Wrap-around: all arithmetic is modulo 2^WIDTH. Only c_out and ovf report the excess.

## Test plan
Use WIDTH=16, CHUNK=4 (N=4) unless stated.
- Zero: a=0000, b=0000, c_in=0, sub=0 → s=0000, c_out=0, ovf=0. done pulses exactly 4 edges after the capture edge, for one cycle. busy is high for 4 cycles.
- Carry ripple across all chunks: a=FFFF, b=0001, c_in=0, sub=0 → s=0000, c_out=1, ovf=0. With c_in=1 and b=FFFF → s=FFFF, c_out=1, ovf=0.
- Signed overflow:
  - Add: a=7FFF, b=0001, sub=0 → s=8000, c_out=0, ovf=1.
  - Subtract: a=8000, b=0001, sub=1, c_in=0 → s=7FFF, c_out=1, ovf=1.
- Subtract with borrow: a=0005, b=0007, sub=1, c_in=0 → s=FFFE, c_out=0, ovf=0. Repeat with c_in=1 → s=FFFD.
- Handshake:
  - start held high during RUN → ignored, and the result matches the first operands.
  - start during the done cycle → new operation captured immediately, and busy=1 next cycle.
  - s holds its old value throughout the second RUN.
- Reset: assert rst_n=0 asynchronously at idx=2 of an operation → busy, done, s, c_out and ovf are 0 immediately. No done appears afterwards. The next start runs correctly. Repeat a directed subset with CHUNK=1, WIDTH=8 and with CHUNK=WIDTH=8.

Source files
------------

// File: rtl/chunked_adder_if.sv
// Operand/result bundle between an operand source (master) and chunked_adder (slave).
interface chunked_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (output start, sub, a, b, c_in, input  busy, done, s, c_out, ovf);
  modport slave  (input  start, sub, a, b, c_in, output busy, done, s, c_out, ovf);
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// rippling the carry between cycles through carry_q.
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  chunked_adder_if.slave bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cOut_q, cOut_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCarry;
  logic             capture;

  always_comb begin
    chunkA = '0;
    chunkB = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        chunkA = opA_q[i*CHUNK +: CHUNK];
        chunkB = opB_q[i*CHUNK +: CHUNK];
      end
    end
    {chunkCarry, chunkSum} = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, carry_q};
  end

  // Subtraction is folded in at capture time: B and the carry are stored already inverted.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    work_d  = work_q;
    s_d     = s_q;
    carry_d = carry_q;
    cOut_d  = cOut_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    capture = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        capture = bus.start;
        state_d = bus.start ? RUN : IDLE;
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDXW'(i)) work_d[i*CHUNK +: CHUNK] = chunkSum;
        end
        carry_d = chunkCarry;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          s_d     = work_d;
          cOut_d  = chunkCarry;
          // Carry into the MSB is recovered from the MSB's own sum bit.
          ovf_d   = chunkA[CHUNK-1] ^ chunkB[CHUNK-1] ^ chunkSum[CHUNK-1] ^ chunkCarry;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      opA_d   = bus.a;
      opB_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? ~bus.c_in : bus.c_in;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      work_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cOut_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      work_q  <= work_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cOut_q  <= cOut_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.s     = s_q;
  assign bus.c_out = cOut_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: 16/4 main instance plus 8/1 and 8/8 variants
// driven in parallel from shared 8-bit stimulus.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(16)) bus16 ();
  chunked_adder_if #(.WIDTH(8))  busBit ();
  chunked_adder_if #(.WIDTH(8))  busWide ();

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut     (.clk(clk), .rst_n(rst_n), .bus(bus16));
  chunked_adder #(.WIDTH(8),  .CHUNK(1)) dutBit  (.clk(clk), .rst_n(rst_n), .bus(busBit));
  chunked_adder #(.WIDTH(8),  .CHUNK(8)) dutWide (.clk(clk), .rst_n(rst_n), .bus(busWide));

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;

  assign busBit.start  = start8;
  assign busBit.sub    = sub8;
  assign busBit.a      = a8;
  assign busBit.b      = b8;
  assign busBit.c_in   = cin8;
  assign busWide.start = start8;
  assign busWide.sub   = sub8;
  assign busWide.a     = a8;
  assign busWide.b     = b8;
  assign busWide.c_in  = cin8;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation and returns #1 after the capture edge with start dropped.
  task automatic applyStimulus(input logic sub, input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.sub   = sub;
    bus16.a     = a;
    bus16.b     = b;
    bus16.c_in  = cin;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
  endtask

  task automatic waitDone16(output int lat, output int busyCnt, output int sChanges);
    logic [15:0] sHeld;
    sHeld    = bus16.s;
    lat      = 0;
    busyCnt  = 0;
    sChanges = 0;
    while (!bus16.done && lat < 20) begin
      if (bus16.busy) busyCnt++;
      if (bus16.s !== sHeld) sChanges++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp16(input string tag, input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] expS, input logic expC, input logic expO);
    int lat, busyCnt, sChanges;
    applyStimulus(sub, a, b, cin);
    waitDone16(lat, busyCnt, sChanges);
    checkOutput({tag, "/latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "/busyCycles"}, 32'(busyCnt), 32'd4);
    checkOutput({tag, "/sHeldInRun"}, 32'(sChanges), 32'd0);
    checkOutput({tag, "/s"}, 32'(bus16.s), 32'(expS));
    checkOutput({tag, "/c_out"}, 32'(bus16.c_out), 32'(expC));
    checkOutput({tag, "/ovf"}, 32'(bus16.ovf), 32'(expO));
    @(posedge clk);
    #1;
    checkOutput({tag, "/doneFalls"}, 32'(bus16.done), 32'd0);
  endtask

  task automatic runOp8(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] expS, input logic expC, input logic expO);
    int latBit, latWide;
    logic [7:0] sBit, sWide;
    logic cBit, cWide, oBit, oWide;
    latBit = -1; latWide = -1;
    sBit = 'x; sWide = 'x; cBit = 'x; cWide = 'x; oBit = 'x; oWide = 'x;
    @(negedge clk);
    start8 = 1'b1; sub8 = sub; a8 = a; b8 = b; cin8 = cin;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int lat = 1; lat <= 12; lat++) begin
      @(posedge clk);
      #1;
      if (busBit.done)  begin latBit  = lat; sBit  = busBit.s;  cBit  = busBit.c_out;  oBit  = busBit.ovf;  end
      if (busWide.done) begin latWide = lat; sWide = busWide.s; cWide = busWide.c_out; oWide = busWide.ovf; end
    end
    checkOutput({tag, "/bit/latency"}, 32'(latBit), 32'd8);
    checkOutput({tag, "/bit/s"}, 32'(sBit), 32'(expS));
    checkOutput({tag, "/bit/c_out"}, 32'(cBit), 32'(expC));
    checkOutput({tag, "/bit/ovf"}, 32'(oBit), 32'(expO));
    checkOutput({tag, "/wide/latency"}, 32'(latWide), 32'd1);
    checkOutput({tag, "/wide/s"}, 32'(sWide), 32'(expS));
    checkOutput({tag, "/wide/c_out"}, 32'(cWide), 32'(expC));
    checkOutput({tag, "/wide/ovf"}, 32'(oWide), 32'(expO));
  endtask

  initial begin
    int lat, busyCnt, sChanges, doneSeen;
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

    #12;
    checkOutput("reset/busy", 32'(bus16.busy), 32'd0);
    checkOutput("reset/done", 32'(bus16.done), 32'd0);
    checkOutput("reset/s", 32'(bus16.s), 32'd0);
    checkOutput("reset/c_out", 32'(bus16.c_out), 32'd0);
    checkOutput("reset/ovf", 32'(bus16.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic arithmetic");
    runOp16("zero",      1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    runOp16("ripple",    1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp16("rippleCin", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    runOp16("ovfAdd",    1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp16("ovfSub",    1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset/busy", 32'(bus16.busy), 32'd0);
    checkOutput("midReset/done", 32'(bus16.done), 32'd0);
    checkOutput("midReset/s", 32'(bus16.s), 32'd0);
    checkOutput("midReset/c_out", 32'(bus16.c_out), 32'd0);
    checkOutput("midReset/ovf", 32'(bus16.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus16.done) doneSeen++;
    end
    checkOutput("midReset/noDone", 32'(doneSeen), 32'd0);

    runOp16("borrow",    1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    runOp16("borrowCin", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b0);

    $display("[TB] handshake");
    @(negedge clk);
    bus16.start = 1'b1; bus16.sub = 1'b0; bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.c_in = 1'b0;
    @(posedge clk);
    #1;
    bus16.a = 16'h0F0F;
    bus16.b = 16'h0101;
    waitDone16(lat, busyCnt, sChanges);
    checkOutput("hold/latency", 32'(lat), 32'd4);
    checkOutput("hold/busyCycles", 32'(busyCnt), 32'd4);
    checkOutput("hold/s", 32'(bus16.s), 32'h2345);
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    checkOutput("b2b/busy", 32'(bus16.busy), 32'd1);
    checkOutput("b2b/done", 32'(bus16.done), 32'd0);
    waitDone16(lat, busyCnt, sChanges);
    checkOutput("b2b/latency", 32'(lat), 32'd4);
    checkOutput("b2b/sHeldInRun", 32'(sChanges), 32'd0);
    checkOutput("b2b/s", 32'(bus16.s), 32'h1010);
    checkOutput("b2b/c_out", 32'(bus16.c_out), 32'd0);

    $display("[TB] 8-bit variants");
    runOp8("w8ripple", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp8("w8ovfAdd", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp8("w8borrow", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    runOp8("w8ovfSub", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
